hazard_forward_unit: RTL
========================

// Module: hazard_forward_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
//  Replaces the freeze-only pipe control and the tied-off EX forwarding
//  selects. Generates the global pipe load enable, IF/ID flush and ID/EX
//  bubble, and per-source EX forwarding selects. Handles cache stalls,
//  load-use hazards and taken-branch flushes, and keeps saturating
//  stall/flush performance counters.
// PARAMETERS
//  NUM_SRC     2   register source operands per instruction
//  REG_AW      5   register address width
//  CNT_W       32  performance counter width
// PORTS
//  clk              in   1               clock
//  reset            in   1               synchronous, active-high
//  icache_req       in   1               read_a | write_a
//  icache_resp      in   1               resp_a (1-cycle pulse)
//  dcache_req       in   1               read_b | write_b (MEM stage)
//  dcache_resp      in   1               resp_b (1-cycle pulse)
//  id_rs            in   NUM_SRC*REG_AW  ID source register addresses
//  id_rs_used       in   NUM_SRC         ID source actually read
//  ex_rs            in   NUM_SRC*REG_AW  EX source register addresses
//  ex_rd            in   REG_AW          EX destination register
//  ex_mem_read      in   1               EX instruction is a load
//  ex_branch_taken  in   1               EX redirects the PC (jump/taken branch)
//  mem_rd           in   REG_AW          MEM destination register
//  mem_load_regfile in   1               MEM instruction writes rd
//  wb_rd            in   REG_AW          WB destination register
//  wb_load_regfile  in   1               WB instruction writes rd
//  load             out  1               global pipe-register load enable
//  if_id_flush      out  1               zero the IF/ID register on this load
//  id_ex_bubble     out  1               load NOP into ID/EX on this load
//  fwd_sel          out  NUM_SRC*2       per EX source: 00 regfile, 01 MEM, 10 WB
//  stall_cycles     out  CNT_W           cycles with load=0 or a load-use bubble
//  flush_count      out  CNT_W           number of flushes applied
// BEHAVIOUR
//  Reset: state=RUN, flush_pend=0, counters=0. load=1; if_id_flush,
//   id_ex_bubble and fwd_sel follow the combinational rules below.
//  mem_stall = (icache_req & !icache_resp) | (dcache_req & !dcache_resp).
//   load = !mem_stall. Purely combinational with 0-cycle latency.
//  Forwarding (combinational, per source i): rs==0 -> 00. Otherwise
//   mem_load_regfile & mem_rd==rs -> 01; else wb_load_regfile & wb_rd==rs -> 10;
//   else 00. MEM has priority over WB.
//  Load-use: ex_mem_read & ex_rd!=0 & any i (id_rs_used[i] & id_rs[i]==ex_rd).
//   On a load cycle, hold PC and IF/ID and set id_ex_bubble=1 for exactly 1 cycle.
//  FSM: RUN, STALL, FLUSH_PEND.
//   RUN: taken branch & load -> assert if_id_flush=id_ex_bubble=1 now, stay RUN.
//        Taken branch & !load -> FLUSH_PEND (set flush_pend).
//        !load -> STALL.
//   STALL: hold; when load=1 -> RUN.
//   FLUSH_PEND: the branch is frozen in EX; on the first cycle with load=1,
//        assert both flushes and return to RUN. ex_branch_taken is ignored
//        here, so the same branch is never double-counted.
//  Priority: a flush beats a load-use (the squashed ID instruction creates
//   no bubble). Any hazard is acted on only on a cycle with load=1.
//  Counters saturate at all-ones. They increment once per qualifying cycle or
//   flush. A reset mid-stall clears state; flush_pend is dropped.
// STRUCTURE
//  rv32i_types: fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB), hz_state_t enum.
//  Sub-module fwd_compare: one source register vs the MEM/WB destinations,
//   returns fwd_sel_t. Instantiated NUM_SRC times in a generate loop.
// TESTING
//  1. MEM add writes x5, EX rs1=x5 -> fwd_sel[1:0]=01. Same with WB only -> 10.
//     rs1=x0 with MEM rd=x0 -> 00.
//  2. MEM and WB both write x7, EX rs2=x7 -> fwd_sel[3:2]=01.
//  3. EX lw x3, ID add uses x3 -> one cycle with id_ex_bubble=1, load=1,
//     stall_cycles +1. Next cycle no bubble.
//  4. icache_req held with resp delayed 4 cycles -> load=0 for 4 cycles, then 1.
//     stall_cycles +4.
//  5. Branch taken while dcache is stalled 3 cycles -> no flush during the
//     stall. Flushes on the resp cycle. flush_count +1 exactly once.
//  6. Branch taken concurrent with a load-use -> flushes asserted, no extra bubble.
//     Reset during STALL -> load=1 and counters 0 next cycle.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the RV32I pipeline hazard/forwarding controller.
package hazard_forward_unit_pkg;

  localparam int unsigned NUM_SRC_DEF = 2;
  localparam int unsigned REG_AW_DEF  = 5;
  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned FWD_SEL_W   = 2;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'b00,
    HZ_STALL      = 2'b01,
    HZ_FLUSH_PEND = 2'b10
  } hz_state_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_compare.sv
// Forwarding select for one EX source operand against the MEM/WB destinations.
module hazard_forward_unit_fwd_compare
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_load_regfile_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_load_regfile_i,
  output fwd_sel_t          sel_o
);

  // x0 is hardwired, so it never takes a bypass; MEM is the younger result.
  always_comb begin
    sel_o = FWD_RF;
    if (rs_i != '0) begin
      if (mem_load_regfile_i && (mem_rd_i == rs_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_load_regfile_i && (wb_rd_i == rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard controller: global load enable, flush/bubble control,
// EX forwarding selects and saturating stall/flush counters.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF,
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        icache_req,
  input  logic                        icache_resp,
  input  logic                        dcache_req,
  input  logic                        dcache_resp,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
  input  logic [REG_AW-1:0]           ex_rd,
  input  logic                        ex_mem_read,
  input  logic                        ex_branch_taken,
  input  logic [REG_AW-1:0]           mem_rd,
  input  logic                        mem_load_regfile,
  input  logic [REG_AW-1:0]           wb_rd,
  input  logic                        wb_load_regfile,
  output logic                        load,
  output logic                        if_id_flush,
  output logic                        id_ex_bubble,
  output logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel,
  output logic [CNT_W-1:0]            stall_cycles,
  output logic [CNT_W-1:0]            flush_count
);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_stall_c;
  logic             load_use_c;
  logic             flush_c;
  logic             bubble_c;
  logic             stall_inc_c;

  assign mem_stall_c = (icache_req && !icache_resp) || (dcache_req && !dcache_resp);
  assign load        = !mem_stall_c;

  // Per-source forwarding comparators.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_sel_t sel;

    hazard_forward_unit_fwd_compare #(
      .REG_AW (REG_AW)
    ) u_cmp (
      .rs_i               (ex_rs[g*REG_AW +: REG_AW]),
      .mem_rd_i           (mem_rd),
      .mem_load_regfile_i (mem_load_regfile),
      .wb_rd_i            (wb_rd),
      .wb_load_regfile_i  (wb_load_regfile),
      .sel_o              (sel)
    );

    assign fwd_sel[g*FWD_SEL_W +: FWD_SEL_W] = sel;
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] == ex_rd)) begin
        load_use_c = 1'b1;
      end
    end
    load_use_c = load_use_c && ex_mem_read && (ex_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Hazards only take effect on a cycle where the pipe actually advances.
  always_comb begin
    state_d     = state_q;
    flush_c     = 1'b0;
    bubble_c    = 1'b0;
    stall_inc_c = 1'b0;

    case (state_q)
      HZ_RUN: begin
        if (load) begin
          flush_c = ex_branch_taken;
        end else if (ex_branch_taken) begin
          state_d = HZ_FLUSH_PEND;
        end else begin
          state_d = HZ_STALL;
        end
      end
      HZ_STALL: begin
        if (load) begin
          state_d = HZ_RUN;
          flush_c = ex_branch_taken;
        end
      end
      HZ_FLUSH_PEND: begin
        // The frozen branch was already recorded; its taken flag is not re-sampled.
        if (load) begin
          state_d = HZ_RUN;
          flush_c = 1'b1;
        end
      end
      default: begin
        state_d = HZ_RUN;
      end
    endcase

    bubble_c    = flush_c || (load && load_use_c);
    stall_inc_c = !load || (load_use_c && !flush_c);
  end

  assign if_id_flush  = flush_c;
  assign id_ex_bubble = bubble_c;

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_c && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule
